// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame scheduler.
// Pure declarations; no latency and no backpressure of its own.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LAST = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int C_DATA_WIDTH_DEF = 32;
    localparam int C_CNT_WIDTH_DEF  = 16;

    // A zero frame length or frame count is treated as this value.
    localparam int LEN_ZERO_SUB = 1;

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// PRBS input stream plus framed AXI-Stream output, seen from the scheduler (master).
// Wiring only: the latency and backpressure are set by whoever drives each side.
interface tx_frame_scheduler_if
    import tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF
);
    logic [C_DATA_WIDTH-1:0] s_prbs_tdata;
    logic                    s_prbs_tvalid;
    logic                    s_prbs_tready;
    logic                    m_axis_tready;
    logic                    m_axis_tvalid;
    logic                    m_axis_sof;
    logic                    m_axis_eof;
    logic [C_DATA_WIDTH-1:0] m_axis_tdata;

    modport master (
        input  s_prbs_tdata, s_prbs_tvalid, m_axis_tready,
        output s_prbs_tready, m_axis_tvalid, m_axis_sof, m_axis_eof, m_axis_tdata
    );

    modport slave (
        output s_prbs_tdata, s_prbs_tvalid, m_axis_tready,
        input  s_prbs_tready, m_axis_tvalid, m_axis_sof, m_axis_eof, m_axis_tdata
    );
endinterface

// File: rtl/tx_axis_out_reg.sv
// Single-stage AXI-Stream output register carrying data and frame markers; 1 cycle load->valid.
// Backpressure: the beat holds stable while tvalid && !tready; slot_free tells the producer when it may load.
module tx_axis_out_reg
    import tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [C_DATA_WIDTH-1:0] load_data,
    input  logic                    load_sof,
    input  logic                    load_eof,
    input  logic                    tready,
    output logic                    tvalid,
    output logic                    sof,
    output logic                    eof,
    output logic [C_DATA_WIDTH-1:0] tdata,
    output logic                    slot_free
);

    assign slot_free = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            sof    <= 1'b0;
            eof    <= 1'b0;
            tdata  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            sof    <= load_sof;
            eof    <= load_eof;
            tdata  <= load_data;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frames the PRBS stream into fixed-length frames with idle gaps; 1 cycle from PRBS accept to output valid.
// Backpressure: PRBS is consumed only in SEND with a free output slot; frames always complete once started.
module tx_frame_scheduler
    import tx_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_CNT_WIDTH  = C_CNT_WIDTH_DEF
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic                   i_enable,
    input  logic                   i_continuous,
    input  logic [C_CNT_WIDTH-1:0] i_frame_len,
    input  logic [C_CNT_WIDTH-1:0] i_gap_len,
    input  logic [C_CNT_WIDTH-1:0] i_num_frames,
    tx_frame_scheduler_if.master   bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [C_CNT_WIDTH-1:0] o_frame_cnt
);

    localparam logic [C_CNT_WIDTH-1:0] LEN_SUB = C_CNT_WIDTH'(LEN_ZERO_SUB);
    localparam logic [C_CNT_WIDTH-1:0] ONE     = C_CNT_WIDTH'(1);

    state_t                 state, state_nxt;
    logic                   en_q;
    logic                   cont_q;
    logic [C_CNT_WIDTH-1:0] frame_len_q, gap_len_q, num_frames_q;
    logic [C_CNT_WIDTH-1:0] beat_cnt, gap_cnt;
    logic [C_CNT_WIDTH-1:0] frame_cnt_inc;
    logic                   slot_free, load, start, eof_hs, last_beat, done_nxt;

    assign start         = (state == IDLE) && i_enable && !en_q;
    assign bus.s_prbs_tready = (state == SEND) && slot_free;
    assign load          = bus.s_prbs_tready && bus.s_prbs_tvalid;
    assign last_beat     = (beat_cnt == frame_len_q - ONE);
    assign eof_hs        = bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_eof;
    assign frame_cnt_inc = o_frame_cnt + ONE;
    assign o_busy        = (state != IDLE);

    tx_axis_out_reg #(.C_DATA_WIDTH(C_DATA_WIDTH)) u_out_reg (
        .clk       (s_axi_aclk),
        .rst_n     (s_axi_aresetn),
        .load      (load),
        .load_data (bus.s_prbs_tdata),
        .load_sof  (beat_cnt == '0),
        .load_eof  (last_beat),
        .tready    (bus.m_axis_tready),
        .tvalid    (bus.m_axis_tvalid),
        .sof       (bus.m_axis_sof),
        .eof       (bus.m_axis_eof),
        .tdata     (bus.m_axis_tdata),
        .slot_free (slot_free)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SEND;
            SEND: if (load && last_beat) state_nxt = LAST;
            LAST: begin
                if (eof_hs) begin
                    if (!cont_q && (frame_cnt_inc == num_frames_q)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (!i_enable) begin
                        state_nxt = IDLE;
                    end else if (gap_len_q != '0) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            GAP: begin
                if (!i_enable)           state_nxt = IDLE;
                else if (gap_cnt == ONE) state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state        <= IDLE;
            en_q         <= 1'b0;
            cont_q       <= 1'b0;
            frame_len_q  <= '0;
            gap_len_q    <= '0;
            num_frames_q <= '0;
            beat_cnt     <= '0;
            gap_cnt      <= '0;
            o_frame_cnt  <= '0;
            o_done       <= 1'b0;
        end else begin
            state  <= state_nxt;
            en_q   <= i_enable;
            o_done <= done_nxt;
            if (start) begin
                frame_len_q  <= (i_frame_len  == '0) ? LEN_SUB : i_frame_len;
                num_frames_q <= (i_num_frames == '0) ? LEN_SUB : i_num_frames;
                gap_len_q    <= i_gap_len;
                cont_q       <= i_continuous;
                o_frame_cnt  <= '0;
                beat_cnt     <= '0;
            end
            if (load) beat_cnt <= beat_cnt + ONE;
            if ((state == LAST) && eof_hs) begin
                o_frame_cnt <= frame_cnt_inc;
                beat_cnt    <= '0;
                if (state_nxt == GAP) gap_cnt <= gap_len_q;
            end
            if (state == GAP) gap_cnt <= gap_cnt - ONE;
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: frame-level reference model, random PRBS data and handshakes.
module tb_tx_frame_scheduler;
    import tx_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          cont = 1'b0;
    logic [CW-1:0] frame_len = '0, gap_len = '0, num_frames = '0;
    logic          busy, done;
    logic [CW-1:0] frame_cnt;

    tx_frame_scheduler_if #(.C_DATA_WIDTH(DW)) bus ();

    tx_frame_scheduler #(.C_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .i_enable      (enable),
        .i_continuous  (cont),
        .i_frame_len   (frame_len),
        .i_gap_len     (gap_len),
        .i_num_frames  (num_frames),
        .bus           (bus),
        .o_busy        (busy),
        .o_done        (done),
        .o_frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sof;
        logic          eof;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] src_q[$];
    int  checks = 0, errors = 0;
    int  done_cnt = 0, beats_seen = 0, popped = 0, stall_left = 0;
    int  rdy_mode = 0, vld_mode = 0, chk_gap = -1, idle = 0;
    bit  counting = 1'b0, mon_off = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Source and sink driver: inputs change 2 time units after the rising edge.
    initial begin
        bit v;
        bus.s_prbs_tvalid = 1'b0;
        bus.s_prbs_tdata  = '0;
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = ~bus.m_axis_tready;
                default: bus.m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            v = (src_q.size() > 0);
            if (vld_mode == 1 && $urandom_range(0, 2) == 0) v = 1'b0;
            if (vld_mode == 2 && stall_left > 0) begin
                v = 1'b0;
                stall_left--;
            end
            bus.s_prbs_tvalid = v;
            bus.s_prbs_tdata  = v ? src_q[0] : '0;
            #1;
            if (v && bus.s_prbs_tready) begin
                void'(src_q.pop_front());
                popped++;
                if (vld_mode == 2 && popped == 2) stall_left = 5;
            end
        end
    end

    // Monitor: a beat is accepted at the next edge when tvalid && tready at this sample.
    initial begin
        beat_t held, e;
        bit    hold;
        hold = 1'b0;
        forever begin
            @(posedge clk); #4;
            if (done === 1'b1) done_cnt++;
            if (mon_off || !rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold)
                check("hold_stable", {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_sof, bus.m_axis_eof},
                      {1'b1, held});
            if (bus.m_axis_tvalid) begin
                if (counting) begin
                    if (chk_gap >= 0) check("gap_idle", idle, chk_gap + 1);
                    counting = 1'b0;
                end
                if (bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat actual=%0h required=none", bus.m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {bus.m_axis_tdata, bus.m_axis_sof, bus.m_axis_eof}, e);
                    end
                    beats_seen++;
                    hold = 1'b0;
                    if (bus.m_axis_eof) begin
                        counting = 1'b1;
                        idle     = 0;
                    end
                end else begin
                    hold = 1'b1;
                    held = {bus.m_axis_tdata, bus.m_axis_sof, bus.m_axis_eof};
                end
            end else begin
                hold = 1'b0;
                if (counting) idle++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #6;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 3000) begin
            cyc();
            k++;
        end
        checks++;
        if (k >= 3000) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d_beats_left required=0", name, exp_q.size());
        end
    endtask

    // One-shot run: the model expects max(len,1)*max(nf,1) beats in source order.
    task automatic run(input int len, input int gap, input int nf, input int rm, input int vm, input int gchk);
        int    l = (len == 0) ? 1 : len;
        int    n = (nf == 0) ? 1 : nf;
        beat_t b;
        logic [DW-1:0] w;
        rdy_mode = rm; vld_mode = vm; chk_gap = gchk;
        popped = 0; stall_left = 0; done_cnt = 0; beats_seen = 0; counting = 1'b0;
        for (int f = 0; f < n; f++)
            for (int i = 0; i < l; i++) begin
                w = $urandom;
                src_q.push_back(w);
                b.dat = w; b.sof = (i == 0); b.eof = (i == l - 1);
                exp_q.push_back(b);
            end
        frame_len = CW'(len); gap_len = CW'(gap); num_frames = CW'(nf); cont = 1'b0;
        @(posedge clk); #1 enable = 1'b1;
        cyc();
        check("cnt_clear", frame_cnt, 0);
        // Config written mid-run must be ignored.
        frame_len = CW'($urandom); gap_len = CW'($urandom); num_frames = CW'($urandom); cont = 1'b1;
        wait_idle("run");
        check("frame_cnt", frame_cnt, n);
        check("done_once", done_cnt, 1);
        check("src_used", src_q.size(), 0);
        repeat (5) cyc();
        check("no_restart_busy", busy, 0);
        check("no_restart_cnt", frame_cnt, n);
        enable = 1'b0;
        cyc();
    endtask

    initial begin
        beat_t b;
        int    k;
        repeat (3) @(posedge clk);
        #6;
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_sof", bus.m_axis_sof, 0);
        check("rst_eof", bus.m_axis_eof, 0);
        check("rst_tdata", bus.m_axis_tdata, 0);
        check("rst_prbs_tready", bus.s_prbs_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc();

        run(4, 2, 3, 0, 0, 2);
        run(1, 0, 2, 0, 0, 0);
        run(8, 0, 1, 1, 0, -1);
        run(4, 0, 1, 0, 2, -1);

        // Continuous, enable dropped after the first beat: frame completes, no more consumed.
        rdy_mode = 0; vld_mode = 0; chk_gap = -1; counting = 1'b0;
        done_cnt = 0; beats_seen = 0;
        for (int i = 0; i < 6; i++) begin
            src_q.push_back($urandom);
            if (i < 3) begin
                b.dat = src_q[i]; b.sof = (i == 0); b.eof = (i == 2);
                exp_q.push_back(b);
            end
        end
        frame_len = 3; gap_len = 0; num_frames = 0; cont = 1'b1;
        @(posedge clk); #1 enable = 1'b1;
        k = 0;
        while (beats_seen < 1 && k < 200) begin cyc(); k++; end
        check("cont_first_beat", beats_seen >= 1, 1);
        enable = 1'b0;
        wait_idle("cont");
        check("cont_frame_cnt", frame_cnt, 1);
        check("cont_no_done", done_cnt, 0);
        check("cont_src_left", src_q.size(), 3);
        repeat (3) cyc();
        check("cont_prbs_tready", bus.s_prbs_tready, 0);
        src_q.delete();

        // Reset while a beat is valid.
        mon_off = 1'b1; rdy_mode = 2;
        for (int i = 0; i < 16; i++) src_q.push_back($urandom);
        frame_len = 8; cont = 1'b1;
        @(posedge clk); #1 enable = 1'b1;
        k = 0;
        while (bus.m_axis_tvalid !== 1'b1 && k < 200) begin cyc(); k++; end
        check("rst_mid_tvalid_seen", bus.m_axis_tvalid, 1);
        @(posedge clk); #1 begin rst_n = 1'b0; enable = 1'b0; end
        cyc();
        check("rst_mid_tvalid", bus.m_axis_tvalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_frame_cnt", frame_cnt, 0);
        #1 rst_n = 1'b1;
        src_q.delete(); exp_q.delete();
        repeat (3) cyc();
        check("rst_stays_idle", busy, 0);
        mon_off = 1'b0;
        run(2, 1, 1, 0, 0, -1);

        for (int r = 0; r < 8; r++)
            run($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 1), -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
